// File: rtl/pipe_adder.sv
// Pipelined ripple adder: each stage adds one CHUNK-wide slice and hands its carry to the next.
// Operand slices still to be added are shifted down a stage at a time; finished sum slices are shifted in at the top.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] vld_q, cy_q, am_q, bm_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] adv, up_vld, up_cy, up_am, up_bm;
    logic [WIDTH-1:0]  up_a  [STAGES];
    logic [WIDTH-1:0]  up_b  [STAGES];
    logic [WIDTH-1:0]  up_s  [STAGES];
    logic [WIDTH-1:0]  nxt_a [STAGES];
    logic [WIDTH-1:0]  nxt_b [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [CHUNK:0]    csum  [STAGES];

    always_comb begin
        up_vld[0] = in_valid;
        up_a[0]   = a;
        up_b[0]   = b;
        up_s[0]   = '0;
        up_cy[0]  = c_in;
        up_am[0]  = a[WIDTH-1];
        up_bm[0]  = b[WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k] = vld_q[k-1];
            up_a[k]   = a_q[k-1];
            up_b[k]   = b_q[k-1];
            up_s[k]   = s_q[k-1];
            up_cy[k]  = cy_q[k-1];
            up_am[k]  = am_q[k-1];
            up_bm[k]  = bm_q[k-1];
        end
    end

    // A stage may move when the consumer takes the result or any bubble exists at or below it.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            logic bubble;
            bubble = 1'b0;
            for (int j = k; j < STAGES; j++) begin
                bubble = bubble | ~vld_q[j];
            end
            adv[k] = out_ready | bubble;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            csum[k]  = {1'b0, up_a[k][CHUNK-1:0]} + {1'b0, up_b[k][CHUNK-1:0]}
                     + (CHUNK+1)'(up_cy[k]);
            nxt_a[k] = up_a[k] >> CHUNK;
            nxt_b[k] = up_b[k] >> CHUNK;
            nxt_s[k] = (up_s[k] >> CHUNK) | (WIDTH'(csum[k][CHUNK-1:0]) << (WIDTH - CHUNK));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= up_vld[k];
                    if (up_vld[k]) begin
                        a_q[k]  <= nxt_a[k];
                        b_q[k]  <= nxt_b[k];
                        s_q[k]  <= nxt_s[k];
                        cy_q[k] <= csum[k][CHUNK];
                        am_q[k] <= up_am[k];
                        bm_q[k] <= up_bm[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rst_n & adv[0];
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign c_out     = cy_q[LAST];
    assign ovf       = (am_q[LAST] == bm_q[LAST]) && (s_q[LAST][WIDTH-1] != am_q[LAST]);

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed corner cases plus randomized traffic against an arithmetic reference queue.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, c_in;
    logic [15:0] in_a, in_b;
    logic        in_ready, out_valid, c_out, ovf;
    logic [15:0] sum;

    logic        in_valid2, c_in2;
    logic [15:0] in_a2, in_b2;
    logic        in_ready2, out_valid2, c_out2, ovf2;
    logic [15:0] sum2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   lat_log[$];
    int   out_log[$];
    logic prev_stall = 1'b0;
    logic [17:0] prev_out;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(in_a), .b(in_b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipe_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(in_a2), .b(in_b2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(1'b1),
        .sum(sum2), .c_out(c_out2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci, input int c);
        exp_t e;
        int   ufull, sfull;
        ufull = int'(x) + int'(y) + int'(ci);
        sfull = int'($signed(x)) + int'($signed(y)) + int'(ci);
        e.sum = ufull[15:0];
        e.co  = ufull >= 65536;
        e.ovf = (sfull > 32767) || (sfull < -32768);
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold", {c_out, ovf, sum}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", {c_out, ovf, sum}, {e.co, e.ovf, e.sum});
                    lat_log.push_back(cyc - e.cyc);
                    out_log.push_back(cyc);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, c_in, cyc));
            prev_stall = out_valid && !out_ready;
            prev_out   = {c_out, ovf, sum};
        end
    end

    task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db,
                            input logic dci, input logic [15:0] es, input logic eco, input logic eovf);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = da; in_b = db; c_in = dci; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, c_out, eco);
        check({tag, "_ovf"}, ovf, eovf);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; c_in = 1'b0; in_a = '0; in_b = '0;
        in_valid2 = 1'b0; c_in2 = 1'b0; in_a2 = '0; in_b2 = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_sum", {c_out, ovf, sum}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        directed("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("all_ones",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        directed("neg_ovf",    16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // eight back-to-back transfers
        repeat (3) @(negedge clk);
        lat_log.delete(); out_log.delete();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); c_in = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b_count", lat_log.size(), 8);
        for (int i = 0; i < lat_log.size(); i++) begin
            check("b2b_lat", lat_log[i], 4);
            check("b2b_consec", out_log[i] - out_log[0], i);
        end

        // fill with consumer stalled, then simultaneous in/out transfer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); c_in = 1'($urandom);
        end
        @(posedge clk); #1;
        in_a = 16'($urandom); in_b = 16'($urandom); c_in = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            check("full_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_both_xfer", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("full_drained", exp_q.size(), 0);

        // CHUNK == WIDTH instance
        @(posedge clk); #1;
        in_valid2 = 1'b1; in_a2 = 16'h1234; in_b2 = 16'h4321; c_in2 = 1'b0;
        @(negedge clk);
        check("c16_in_ready", in_ready2, 1);
        check("c16_pre_valid", out_valid2, 0);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("c16_valid", out_valid2, 1);
        check("c16_sum", {c_out2, ovf2, sum2}, {2'b00, 16'h5555});

        // reset with three transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); c_in = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid) stale++;
            end
            check("rst_no_stale", stale, 0);
        end

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_a = 16'($urandom); in_b = 16'($urandom); c_in = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
